// File: rtl/prio_encoder_hold_if.sv
// Request/grant bundle between a bank of request lines, the encoder and its
// downstream consumer. The encoder sits on the slave side; the requester/consumer
// (or a testbench) sits on the master side.
interface prio_encoder_hold_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req_i;
  logic         ack_i;
  logic         valid_o;
  logic [W-1:0] code_o;
  logic [N-1:0] onehot_o;
  logic         multi_o;

  modport master (
    output req_i, ack_i,
    input  valid_o, code_o, onehot_o, multi_o
  );

  modport slave (
    input  req_i, ack_i,
    output valid_o, code_o, onehot_o, multi_o
  );
endinterface

// File: rtl/prio_encoder_hold.sv
// Registered N-to-log2(N) priority encoder with grant hold.
// A winning code is loaded when idle or when the consumer acks the current one,
// and is then frozen until acked. Selection is fixed priority (lowest index) or
// round-robin, where the search starts just past the last accepted code.
// All outputs come straight from flops; req_i/ack_i only steer the next load.
module prio_encoder_hold #(
  parameter int N  = 8,
  parameter int W  = 3,
  parameter int RR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  prio_encoder_hold_if.slave bus
);

  // Elaboration-time sanity on the parameter set.
  if (N < 2 || N > 32) begin : g_n_chk
    $error("prio_encoder_hold: N must be in 2..32");
  end
  if (W != $clog2(N)) begin : g_w_chk
    $error("prio_encoder_hold: W must equal clog2(N)");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state;
  logic [W-1:0] ptr;
  logic [W-1:0] code_r;
  logic [N-1:0] onehot_r;
  logic         multi_r;

  logic         transfer;
  logic         load;
  logic [W-1:0] base;
  logic [N-1:0] rot;
  logic         found;
  logic [W-1:0] win;
  logic         multi_nxt;

  // Modulo-N increment; explicit wrap so non-power-of-two N never reaches 2^W.
  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] c);
    return (c == W'(N - 1)) ? '0 : c + W'(1);
  endfunction

  assign transfer  = (state == HOLD) && bus.ack_i;
  assign load      = (state == IDLE) || bus.ack_i;
  assign multi_nxt = |(bus.req_i & (bus.req_i - N'(1)));

  // Search base: code after the one being accepted, else the saved pointer.
  always_comb begin
    base = '0;
    if (RR != 0) begin
      base = (state == HOLD) ? inc_mod(code_r) : ptr;
    end
  end

  // Rotate the request vector so the search always starts at bit 0, then map
  // the first set position back to an absolute index modulo N.
  always_comb begin
    logic [2*N-1:0] dbl;
    logic [W:0]     sum;
    dbl   = {bus.req_i, bus.req_i};
    rot   = N'(dbl >> base);
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, base} + (W+1)'(k);
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        win   = sum[W-1:0];
      end
    end
  end

  // Grant FSM: load on idle or transfer, otherwise hold every output frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      code_r   <= '0;
      onehot_r <= '0;
      multi_r  <= 1'b0;
    end else if (load) begin
      if (transfer && RR != 0) ptr <= inc_mod(code_r);
      if (found) begin
        state    <= HOLD;
        code_r   <= win;
        onehot_r <= N'(1) << win;
        multi_r  <= multi_nxt;
      end else begin
        state    <= IDLE;
        code_r   <= '0;
        onehot_r <= '0;
        multi_r  <= 1'b0;
      end
    end
  end

  assign bus.valid_o  = (state == HOLD);
  assign bus.code_o   = code_r;
  assign bus.onehot_o = onehot_r;
  assign bus.multi_o  = multi_r;

endmodule

// File: tb/tb_prio_encoder_hold.sv
// Directed bench: fixed-priority N=8, round-robin N=8 and round-robin N=5
// instances, each exercised by its own scenario tasks.
module tb_prio_encoder_hold;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  prio_encoder_hold_if #(.N(8), .W(3)) b0();
  prio_encoder_hold_if #(.N(8), .W(3)) b1();
  prio_encoder_hold_if #(.N(5), .W(3)) b2();

  prio_encoder_hold #(.N(8), .W(3), .RR(0)) u0 (.clk(clk), .rst_n(rst0), .bus(b0.slave));
  prio_encoder_hold #(.N(8), .W(3), .RR(1)) u1 (.clk(clk), .rst_n(rst1), .bus(b1.slave));
  prio_encoder_hold #(.N(5), .W(3), .RR(1)) u2 (.clk(clk), .rst_n(rst2), .bus(b2.slave));

  // Packed view {valid, code, onehot, multi} for one-shot comparisons.
  wire [12:0] o0 = {b0.valid_o, b0.code_o, b0.onehot_o, b0.multi_o};
  wire [12:0] o1 = {b1.valid_o, b1.code_o, b1.onehot_o, b1.multi_o};
  wire [9:0]  o2 = {b2.valid_o, b2.code_o, b2.onehot_o, b2.multi_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 0; rst1 = 0; rst2 = 0;
    b0.req_i = 8'hFF; b1.req_i = 8'hFF; b2.req_i = 5'h1F;
    b0.ack_i = 1; b1.ack_i = 1; b2.ack_i = 1;
    tick(); tick();
    checks++; if (o0 !== 13'h0) begin failures++; $display("FAIL reset_u0 got=%h exp=%h", o0, 13'h0); end
    checks++; if (o1 !== 13'h0) begin failures++; $display("FAIL reset_u1 got=%h exp=%h", o1, 13'h0); end
    checks++; if (o2 !== 10'h0) begin failures++; $display("FAIL reset_u2 got=%h exp=%h", o2, 10'h0); end
    rst0 = 1; rst1 = 1; rst2 = 1;
    tick();
    b0.ack_i = 0; b1.ack_i = 0; b2.ack_i = 0;
    checks++; if (o0 !== {1'b1, 3'd0, 8'h01, 1'b1}) begin failures++; $display("FAIL release_u0 got=%h exp=%h", o0, {1'b1, 3'd0, 8'h01, 1'b1}); end
    checks++; if (o1 !== {1'b1, 3'd0, 8'h01, 1'b1}) begin failures++; $display("FAIL release_u1 got=%h exp=%h", o1, {1'b1, 3'd0, 8'h01, 1'b1}); end
    checks++; if (o2 !== {1'b1, 3'd0, 5'h01, 1'b1}) begin failures++; $display("FAIL release_u2 got=%h exp=%h", o2, {1'b1, 3'd0, 5'h01, 1'b1}); end
  endtask

  task automatic test_fixed_hold();
    b0.req_i = 8'h00; b0.ack_i = 1;
    tick();
    checks++; if (o0 !== 13'h0) begin failures++; $display("FAIL fh_drain got=%h exp=%h", o0, 13'h0); end
    b0.ack_i = 0; b0.req_i = 8'b0010_1000;
    tick();
    checks++; if (o0 !== {1'b1, 3'd3, 8'h08, 1'b1}) begin failures++; $display("FAIL fh_load got=%h exp=%h", o0, {1'b1, 3'd3, 8'h08, 1'b1}); end
    b0.req_i = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o0 !== {1'b1, 3'd3, 8'h08, 1'b1}) begin failures++; $display("FAIL fh_hold%0d got=%h exp=%h", i, o0, {1'b1, 3'd3, 8'h08, 1'b1}); end
    end
    b0.ack_i = 1;
    tick();
    b0.ack_i = 0;
    checks++; if (o0 !== {1'b1, 3'd0, 8'h01, 1'b0}) begin failures++; $display("FAIL fh_ack got=%h exp=%h", o0, {1'b1, 3'd0, 8'h01, 1'b0}); end
  endtask

  task automatic test_drain();
    b0.req_i = 8'h00; b0.ack_i = 1;
    tick();
    checks++; if (o0 !== 13'h0) begin failures++; $display("FAIL drain_idle got=%h exp=%h", o0, 13'h0); end
    tick();
    b0.ack_i = 0;
    checks++; if (o0 !== 13'h0) begin failures++; $display("FAIL drain_ack_pulse got=%h exp=%h", o0, 13'h0); end
    tick();
    checks++; if (o0 !== 13'h0) begin failures++; $display("FAIL drain_quiet got=%h exp=%h", o0, 13'h0); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_code;
    b1.req_i = 8'hFF; b1.ack_i = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_code = 3'(i + 1);
      checks++; if (o1 !== {1'b1, exp_code, 8'h01 << exp_code, 1'b1}) begin failures++; $display("FAIL rr_stream%0d got=%h exp=%h", i, o1, {1'b1, exp_code, 8'h01 << exp_code, 1'b1}); end
    end
    b1.ack_i = 0;
  endtask

  task automatic test_rr_wrap();
    b1.req_i = 8'b0000_0100; b1.ack_i = 1;
    tick();
    checks++; if (o1 !== {1'b1, 3'd2, 8'h04, 1'b0}) begin failures++; $display("FAIL rr_grant2 got=%h exp=%h", o1, {1'b1, 3'd2, 8'h04, 1'b0}); end
    b1.req_i = 8'b0000_0011;
    tick();
    checks++; if (o1 !== {1'b1, 3'd0, 8'h01, 1'b1}) begin failures++; $display("FAIL rr_wrap got=%h exp=%h", o1, {1'b1, 3'd0, 8'h01, 1'b1}); end
    tick();
    b1.ack_i = 0;
    checks++; if (o1 !== {1'b1, 3'd1, 8'h02, 1'b1}) begin failures++; $display("FAIL rr_skip got=%h exp=%h", o1, {1'b1, 3'd1, 8'h02, 1'b1}); end
  endtask

  task automatic test_np2_reset_mid_hold();
    b2.req_i = 5'b10001; b2.ack_i = 1;
    tick();
    checks++; if (o2 !== {1'b1, 3'd4, 5'h10, 1'b1}) begin failures++; $display("FAIL np2_g4 got=%h exp=%h", o2, {1'b1, 3'd4, 5'h10, 1'b1}); end
    tick();
    checks++; if (o2 !== {1'b1, 3'd0, 5'h01, 1'b1}) begin failures++; $display("FAIL np2_wrap got=%h exp=%h", o2, {1'b1, 3'd0, 5'h01, 1'b1}); end
    tick();
    b2.ack_i = 0;
    checks++; if (o2 !== {1'b1, 3'd4, 5'h10, 1'b1}) begin failures++; $display("FAIL np2_g4b got=%h exp=%h", o2, {1'b1, 3'd4, 5'h10, 1'b1}); end
    tick();
    checks++; if (o2 !== {1'b1, 3'd4, 5'h10, 1'b1}) begin failures++; $display("FAIL np2_hold got=%h exp=%h", o2, {1'b1, 3'd4, 5'h10, 1'b1}); end
    rst2 = 0;
    tick();
    checks++; if (o2 !== 10'h0) begin failures++; $display("FAIL np2_rst got=%h exp=%h", o2, 10'h0); end
    rst2 = 1;
    tick();
    checks++; if (o2 !== {1'b1, 3'd0, 5'h01, 1'b1}) begin failures++; $display("FAIL np2_ptr_clr got=%h exp=%h", o2, {1'b1, 3'd0, 5'h01, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_fixed_hold();
    test_drain();
    test_back_to_back();
    test_rr_wrap();
    test_np2_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
